shifter: RTL and testbench
==========================

SHIFTER -- requirements
Module: Shifter

Interface
REQ-001 No parameters; all widths fixed.
REQ-002 clk  input  1  single clock; rising edge only.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 Shift_In  input  16  operand to shift.
REQ-005 Shift_Val  input  4  shift amount, unsigned, range 0-15.
REQ-006 Mode  input  1  0 = logical shift left (SLL); 1 = arithmetic shift right (ASR).
REQ-007 Shift_Out  output  16  combinational shift result.
REQ-008 Shift_Out_Q  output  16  Shift_Out registered on clk.

Function
REQ-009 Mode=0: Shift_Out SHALL equal Shift_In shifted left by Shift_Val, zero-filled from bit 0, truncated to 16 bits.
REQ-010 Mode=1: Shift_Out SHALL equal Shift_In shifted right by Shift_Val as a signed 16-bit value, filled with copies of Shift_In[15].
REQ-011 Shift_Val=0 SHALL pass Shift_In unchanged in both modes.
REQ-012 Shift_Val=15, Mode=1: Shift_Out SHALL be 0xFFFF if Shift_In[15]=1, else 0x0000.
REQ-013 Shift_Val=15, Mode=0: Shift_Out SHALL be {Shift_In[0], 15'b0}.
REQ-014 Shift_Out SHALL be purely combinational from Shift_In, Shift_Val and Mode, with zero-cycle latency.
REQ-015 Shift_Out SHALL NOT depend on clk or rst.
REQ-016 Shift_Out SHALL settle within one combinational path, with no latches.
REQ-017 The shifter SHALL be a 4-stage logarithmic barrel structure.
REQ-018 The four stages SHALL shift by 1, 2, 4 and 8, enabled by Shift_Val[0], [1], [2] and [3] respectively.
REQ-019 Each stage SHALL select its fill bit by Mode: 0 for SLL, the sign bit for ASR.
REQ-020 Shift_Out_Q SHALL load Shift_Out on every rising clk edge while rst=0, giving 1-cycle latency.
REQ-021 Shift_Out_Q SHALL have no enable and no hold state.
REQ-022 Input changes between clock edges SHALL affect Shift_Out immediately.
REQ-023 Input changes between clock edges SHALL affect Shift_Out_Q only at the next rising edge.

Reset
REQ-024 While rst=1, Shift_Out_Q SHALL be 0x0000, asynchronously, independent of clk.
REQ-025 Reset asserted mid-operation SHALL clear Shift_Out_Q immediately; Shift_Out SHALL continue to track its inputs.
REQ-026 After rst deasserts, the first rising clk edge SHALL load the current Shift_Out into Shift_Out_Q.
REQ-027 X or Z on Mode or Shift_Val is outside the legal input space, and no output value is required for it.

Verification
REQ-028 SLL: Shift_In=0x0001, Shift_Val=15, Mode=0 -> Shift_Out=0x8000; Shift_In=0x1234, Shift_Val=4 -> 0x2340.
REQ-029 ASR negative: Shift_In=0x8000, Shift_Val=15, Mode=1 -> 0xFFFF; Shift_In=0xF0F0, Shift_Val=4 -> 0xFF0F.
REQ-030 ASR positive: Shift_In=0x7FFF, Shift_Val=4, Mode=1 -> 0x07FF; Shift_Val=15 -> 0x0000.
REQ-031 Zero shift: Shift_In=0xA5A5, Shift_Val=0, Mode=0 and Mode=1 -> 0xA5A5 both.
REQ-032 Register path: assert rst -> Shift_Out_Q=0x0000 before any clk edge; release rst; apply 0x0003, Shift_Val=2, Mode=0 -> Shift_Out_Q=0x000C after the next rising edge; assert rst mid-cycle -> Shift_Out_Q=0x0000 immediately.
REQ-033 Random: 100000 random {Mode, Shift_Val, Shift_In} vectors -> Shift_Out SHALL match a reference model (logical left shift for Mode=0, signed arithmetic right shift for Mode=1).
REQ-034 Random: the bench SHALL count passing SLL and ASR operations separately and stop at the first mismatch, reporting operand, amount, mode, expected and actual values.

Source files
------------

// File: rtl/shifter.sv
// 16-bit logarithmic barrel shifter: logical shift left or arithmetic shift right,
// with a combinational result and a registered copy that clears asynchronously on reset.
module shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Shift_In,
  input  logic [3:0]  Shift_Val,
  input  logic        Mode,
  output logic [15:0] Shift_Out,
  output logic [15:0] Shift_Out_Q
);

  logic        w_fill;
  logic [15:0] w_stage1;
  logic [15:0] w_stage2;
  logic [15:0] w_stage4;
  logic [15:0] w_stage8;

  // The sign bit survives every ASR stage unchanged, so one fill bit serves all four stages.
  assign w_fill = Mode & Shift_In[15];

  always_comb begin
    w_stage1 = Shift_In;
    if (Shift_Val[0]) begin
      w_stage1 = Mode ? {w_fill, Shift_In[15:1]} : {Shift_In[14:0], 1'b0};
    end

    w_stage2 = w_stage1;
    if (Shift_Val[1]) begin
      w_stage2 = Mode ? {{2{w_fill}}, w_stage1[15:2]} : {w_stage1[13:0], 2'b00};
    end

    w_stage4 = w_stage2;
    if (Shift_Val[2]) begin
      w_stage4 = Mode ? {{4{w_fill}}, w_stage2[15:4]} : {w_stage2[11:0], 4'h0};
    end

    w_stage8 = w_stage4;
    if (Shift_Val[3]) begin
      w_stage8 = Mode ? {{8{w_fill}}, w_stage4[15:8]} : {w_stage4[7:0], 8'h00};
    end
  end

  assign Shift_Out = w_stage8;

  // Free-running output register: no enable, reloads on every edge out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Shift_Out_Q <= 16'h0000;
    end else begin
      Shift_Out_Q <= w_stage8;
    end
  end

endmodule

// File: tb/tb_shifter.sv
// Self-checking bench for shifter: directed vectors, register/reset path,
// and a random sweep against a behavioural shift model via a scoreboard queue.
module tb_shifter;

  logic        clk;
  logic        rst;
  logic [15:0] Shift_In;
  logic [3:0]  Shift_Val;
  logic        Mode;
  logic [15:0] Shift_Out;
  logic [15:0] Shift_Out_Q;

  int          testsRun;
  int          testsFailed;
  int          sllPass;
  int          asrPass;
  logic [15:0] expQ[$];
  bit          ok;

  shifter dut (
    .clk        (clk),
    .rst        (rst),
    .Shift_In   (Shift_In),
    .Shift_Val  (Shift_Val),
    .Mode       (Mode),
    .Shift_Out  (Shift_Out),
    .Shift_Out_Q(Shift_Out_Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] refShift(input logic [15:0] din, input logic [3:0] amt,
                                           input logic md);
    logic signed [15:0] sdin;
    sdin = din;
    if (md) return 16'(sdin >>> amt);
    return din << amt;
  endfunction

  // Drive the inputs and record what the DUT should produce for them.
  task automatic applyStimulus(input logic [15:0] din, input logic [3:0] amt, input logic md,
                               input logic [15:0] expected);
    Shift_In  = din;
    Shift_Val = amt;
    Mode      = md;
    expQ.push_back(expected);
  endtask

  task automatic expectValue(input logic [15:0] expected);
    expQ.push_back(expected);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, output bit pass);
    logic [15:0] expected;
    testsRun++;
    pass = 1'b1;
    if (expQ.size() == 0) begin
      testsFailed++;
      pass = 1'b0;
      $error("[TB] FAIL %s: observed %h, scoreboard empty", tag, observed);
    end else begin
      expected = expQ.pop_front();
      assert (observed === expected)
      else begin
        testsFailed++;
        pass = 1'b0;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    sllPass     = 0;
    asrPass     = 0;
    rst         = 1'b1;
    Shift_In    = 16'h0000;
    Shift_Val   = 4'd0;
    Mode        = 1'b0;

    #1;
    expectValue(16'h0000);
    checkOutput("reset_q_before_clk", Shift_Out_Q, ok);

    // Directed vectors; sampling at even times keeps clear of the odd-time rising edges.
    @(negedge clk);
    applyStimulus(16'h0001, 4'd15, 1'b0, 16'h8000); #2 checkOutput("sll_1_by15", Shift_Out, ok);
    applyStimulus(16'h1234, 4'd4,  1'b0, 16'h2340); #2 checkOutput("sll_1234_by4", Shift_Out, ok);
    applyStimulus(16'hFFFF, 4'd15, 1'b0, 16'h8000); #2 checkOutput("sll_ffff_by15", Shift_Out, ok);
    applyStimulus(16'h8000, 4'd15, 1'b1, 16'hFFFF); #2 checkOutput("asr_8000_by15", Shift_Out, ok);
    applyStimulus(16'hF0F0, 4'd4,  1'b1, 16'hFF0F); #2 checkOutput("asr_f0f0_by4", Shift_Out, ok);
    applyStimulus(16'h7FFF, 4'd4,  1'b1, 16'h07FF); #2 checkOutput("asr_7fff_by4", Shift_Out, ok);
    applyStimulus(16'h7FFF, 4'd15, 1'b1, 16'h0000); #2 checkOutput("asr_7fff_by15", Shift_Out, ok);
    applyStimulus(16'hA5A5, 4'd0,  1'b0, 16'hA5A5); #2 checkOutput("zero_sll", Shift_Out, ok);
    applyStimulus(16'hA5A5, 4'd0,  1'b1, 16'hA5A5); #2 checkOutput("zero_asr", Shift_Out, ok);
    applyStimulus(16'hA5A5, 4'd8,  1'b1, 16'hFFA5); #2 checkOutput("asr_a5a5_by8", Shift_Out, ok);
    applyStimulus(16'h00FF, 4'd8,  1'b0, 16'hFF00); #2 checkOutput("sll_00ff_by8", Shift_Out, ok);
    expectValue(16'h0000);
    checkOutput("reset_q_held", Shift_Out_Q, ok);

    // Register path: release reset, then check load, hold between edges and async clear.
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'h0003, 4'd2, 1'b0, 16'h000C);
    #2 checkOutput("comb_0003_by2", Shift_Out, ok);
    expectValue(16'h000C);
    @(posedge clk); #1 checkOutput("q_first_load", Shift_Out_Q, ok);
    #2 applyStimulus(16'hA5A5, 4'd1, 1'b1, 16'hD2D2);
    #1 checkOutput("comb_midcycle", Shift_Out, ok);
    expectValue(16'h000C);
    checkOutput("q_holds_midcycle", Shift_Out_Q, ok);
    expectValue(16'hD2D2);
    @(posedge clk); #1 checkOutput("q_next_edge", Shift_Out_Q, ok);
    #2 rst = 1'b1;
    #1 expectValue(16'h0000);
    checkOutput("q_async_clear", Shift_Out_Q, ok);
    applyStimulus(16'hF0F0, 4'd4, 1'b1, 16'hFF0F);
    #1 checkOutput("comb_tracks_in_reset", Shift_Out, ok);
    expectValue(16'h0000);
    @(posedge clk); #1 checkOutput("q_stays_in_reset", Shift_Out_Q, ok);
    @(negedge clk);
    rst = 1'b0;
    expectValue(16'hFF0F);
    @(posedge clk); #1 checkOutput("q_load_after_release", Shift_Out_Q, ok);

    // Random sweep against the behavioural model; stops at the first disagreement.
    @(negedge clk);
    for (int i = 0; i < 100000; i++) begin
      logic [15:0] rin;
      logic [3:0]  ramt;
      logic        rmd;
      rin  = 16'($urandom);
      ramt = 4'($urandom_range(15, 0));
      rmd  = 1'($urandom_range(1, 0));
      applyStimulus(rin, ramt, rmd, refShift(rin, ramt, rmd));
      #2 checkOutput("rand", Shift_Out, ok);
      if (!ok) begin
        $display("[TB] FAIL rand detail: in=%h amt=%0d mode=%0d expected=%h actual=%h",
                 rin, ramt, rmd, refShift(rin, ramt, rmd), Shift_Out);
        break;
      end
      if (rmd) asrPass++;
      else     sllPass++;
    end
    $display("[TB] random passes: SLL=%0d ASR=%0d", sllPass, asrPass);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
